// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants and operand types for the
// pipelined adder and its helper blocks.
package fp32_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned SIG_W   = MAN_W + 1;   // significand with hidden bit
    localparam int unsigned EXT_W   = SIG_W + 3;   // plus guard/round/sticky
    localparam int unsigned EXPN_W  = EXP_W + 2;   // signed exponent headroom
    localparam int unsigned LZ_W    = 5;
    localparam int unsigned EXP_INF = 2 * BIAS + 1;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unp_t;

    // Subnormals collapse to signed zero with an all-zero significand.
    function automatic fp_unp_t fp_unpack(input fp32_t f);
        fp_unp_t u;
        u.sign    = f.sign;
        u.is_zero = (f.exp == '0);
        u.is_inf  = (f.exp == '1) && (f.man == '0);
        u.is_nan  = (f.exp == '1) && (f.man != '0);
        u.exp     = f.exp;
        u.sig     = u.is_zero ? '0 : {1'b1, f.man};
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the extended significand; all-zero input
// reports the full width.
module fp_lzc
    import fp32_pkg::*;
(
    input  logic [EXT_W-1:0] value,
    output logic [LZ_W-1:0]  count_c
);

    always_comb begin
        count_c = LZ_W'(EXT_W);
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (value[i]) begin
                count_c = LZ_W'(int'(EXT_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_add_pipe.sv
// Pipelined binary32 adder: input capture, then align / add-normalize /
// round-pack stages; one pair per clock, result three edges after capture.
module fp32_add_pipe
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    output logic [31:0] Result
);

    logic [31:0] a_q, b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A1;
            b_q <= B1;
        end
    end

    // S1: classify, order by magnitude, align the smaller operand
    fp_unp_t          ua, ub;
    logic             a_ge;
    logic             x_sign, y_sign;
    logic [EXP_W-1:0] x_exp, y_exp, shamt;
    logic [SIG_W-1:0] x_sig, y_sig;
    logic [EXT_W-1:0] y_ext, y_mask, y_al;
    logic             sp_c;
    logic [31:0]      sp_val_c;

    always_comb begin
        ua       = fp_unpack(fp32_t'(a_q));
        ub       = fp_unpack(fp32_t'(b_q));
        a_ge     = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
        x_sign   = a_ge ? ua.sign : ub.sign;
        x_exp    = a_ge ? ua.exp  : ub.exp;
        x_sig    = a_ge ? ua.sig  : ub.sig;
        y_sign   = a_ge ? ub.sign : ua.sign;
        y_exp    = a_ge ? ub.exp  : ua.exp;
        y_sig    = a_ge ? ub.sig  : ua.sig;
        shamt    = x_exp - y_exp;
        y_ext    = {y_sig, 3'b000};
        y_mask   = '0;
        y_al     = '0;
        sp_c     = 1'b0;
        sp_val_c = '0;

        if (shamt >= EXP_W'(EXT_W - 1)) begin
            y_al = EXT_W'(|y_sig);
        end else begin
            y_mask = (EXT_W'(1) << shamt) - EXT_W'(1);
            y_al   = (y_ext >> shamt) | EXT_W'(|(y_ext & y_mask));
        end

        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
            sp_c     = 1'b1;
            sp_val_c = QNAN;
        end else if (ua.is_inf) begin
            sp_c     = 1'b1;
            sp_val_c = {ua.sign, POS_INF[30:0]};
        end else if (ub.is_inf) begin
            sp_c     = 1'b1;
            sp_val_c = {ub.sign, POS_INF[30:0]};
        end else if (ua.is_zero && ub.is_zero) begin
            // only (-0)+(-0) keeps the negative sign
            sp_c     = 1'b1;
            sp_val_c = {ua.sign & ub.sign, 31'b0};
        end
    end

    logic             s1_special, s1_sign, s1_sub;
    logic [31:0]      s1_spval;
    logic [EXP_W-1:0] s1_exp;
    logic [EXT_W-1:0] s1_sigx, s1_sigy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_special <= 1'b0;
            s1_spval   <= '0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_exp     <= '0;
            s1_sigx    <= '0;
            s1_sigy    <= '0;
        end else begin
            s1_special <= sp_c;
            s1_spval   <= sp_val_c;
            s1_sign    <= x_sign;
            s1_sub     <= x_sign ^ y_sign;
            s1_exp     <= x_exp;
            s1_sigx    <= {x_sig, 3'b000};
            s1_sigy    <= y_al;
        end
    end

    // S2: magnitude add/subtract and normalize
    logic [EXT_W:0]          sum_c;
    logic [LZ_W-1:0]         lz_c;
    logic [EXT_W-1:0]        norm_c;
    logic signed [EXPN_W-1:0] exp_base_c, exp_c;

    assign sum_c = s1_sub ? ({1'b0, s1_sigx} - {1'b0, s1_sigy})
                          : ({1'b0, s1_sigx} + {1'b0, s1_sigy});

    fp_lzc u_lzc (
        .value   (sum_c[EXT_W-1:0]),
        .count_c (lz_c)
    );

    always_comb begin
        exp_base_c = $signed(EXPN_W'(s1_exp));
        norm_c     = '0;
        exp_c      = exp_base_c;
        if (sum_c[EXT_W]) begin
            norm_c = {sum_c[EXT_W:2], |sum_c[1:0]};
            exp_c  = exp_base_c + $signed(EXPN_W'(1));
        end else begin
            // a zero sum shifts out entirely, clearing the hidden bit
            norm_c = sum_c[EXT_W-1:0] << lz_c;
            exp_c  = exp_base_c - $signed(EXPN_W'(lz_c));
        end
    end

    logic                     s2_special, s2_sign;
    logic [31:0]              s2_spval;
    logic signed [EXPN_W-1:0] s2_exp;
    logic [EXT_W-1:0]         s2_norm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_special <= 1'b0;
            s2_spval   <= '0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_norm    <= '0;
        end else begin
            s2_special <= s1_special;
            s2_spval   <= s1_spval;
            s2_sign    <= s1_sign;
            s2_exp     <= exp_c;
            s2_norm    <= norm_c;
        end
    end

    // S3: round to nearest even; mantissa carry ripples into the exponent
    logic                     rnd_c;
    logic [EXPN_W+MAN_W-1:0]  packed_c;
    logic signed [EXPN_W-1:0] exp_r_c;
    logic [31:0]              res_c;

    always_comb begin
        rnd_c    = s2_norm[2] & (s2_norm[1] | s2_norm[0] | s2_norm[3]);
        packed_c = {s2_exp, s2_norm[EXT_W-2:3]} + (EXPN_W + MAN_W)'(rnd_c);
        exp_r_c  = $signed(packed_c[EXPN_W+MAN_W-1:MAN_W]);
        res_c    = {s2_sign, exp_r_c[EXP_W-1:0], packed_c[MAN_W-1:0]};
        if (s2_special) begin
            res_c = s2_spval;
        end else if (!s2_norm[EXT_W-1]) begin
            res_c = '0;
        end else if (exp_r_c >= $signed(EXPN_W'(EXP_INF))) begin
            res_c = {s2_sign, POS_INF[30:0]};
        end else if (exp_r_c < $signed(EXPN_W'(1))) begin
            res_c = {s2_sign, 31'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result <= '0;
        end else begin
            Result <= res_c;
        end
    end

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Bench for fp32_add_pipe: directed corner cases and a random stream with a
// mid-stream reset, checked against a real-arithmetic reference model.
module tb_fp32_add_pipe;
    import fp32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A1, B1, Result;

    int checks = 0;
    int errors = 0;

    logic [31:0] hist [0:3];
    string       htag [0:3];

    fp32_add_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .A1     (A1),
        .B1     (B1),
        .Result (Result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flush(input logic [31:0] f);
        return (f[30:23] == 8'h00) ? {f[31], 31'b0} : f;
    endfunction

    // Exact widening of a normal binary32 value into a double.
    function automatic real to_real(input logic [31:0] f);
        if (f[30:23] == 8'h00) return 0.0;
        return $bitstoreal({f[31], 11'(int'(f[30:23]) + 1023 - int'(BIAS)), f[22:0], 29'b0});
    endfunction

    // Round a double to binary32 (nearest, ties to even), flushing tiny results.
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] d;
        logic [24:0] sig;
        logic [28:0] rem;
        int          ue;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'b0};
        ue  = int'(d[62:52]) - 1023;
        sig = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && sig[0])) sig = sig + 25'd1;
        if (sig[24]) begin
            sig = sig >> 1;
            ue  = ue + 1;
        end
        if (ue > 127)  return {d[63], 8'hFF, 23'b0};
        if (ue < -126) return {d[63], 31'b0};
        return {d[63], 8'(ue + 127), sig[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] fa, fb;
        logic        a_nan, b_nan, a_inf, b_inf;
        fa    = flush(a);
        fb    = flush(b);
        a_nan = (fa[30:23] == 8'hFF) && (fa[22:0] != 23'd0);
        b_nan = (fb[30:23] == 8'hFF) && (fb[22:0] != 23'd0);
        a_inf = (fa[30:23] == 8'hFF) && (fa[22:0] == 23'd0);
        b_inf = (fb[30:23] == 8'hFF) && (fb[22:0] == 23'd0);
        if (a_nan || b_nan) return QNAN;
        if (a_inf && b_inf) return (fa[31] != fb[31]) ? QNAN : fa;
        if (a_inf) return fa;
        if (b_inf) return fb;
        if (fa[30:0] == 31'd0 && fb[30:0] == 31'd0) return {fa[31] & fb[31], 31'b0};
        return to_f32(to_real(fa) + to_real(fb));
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] other, input int mode);
        logic [7:0] e;
        case (mode)
            1: return {~other[31], other[30:0] ^ 31'($urandom_range(0, 7))};
            2: begin
                e = other[30:23] + 8'($urandom_range(0, 40)) - 8'd20;
                return {1'($urandom), e, 23'($urandom)};
            end
            3: case ($urandom_range(0, 7))
                0: return 32'h00000000;
                1: return 32'h80000000;
                2: return 32'h7F800000;
                3: return 32'hFF800000;
                4: return 32'h7FC00000;
                5: return 32'h7F7FFFFF;
                6: return 32'h00000001;
                default: return 32'h00800000;
            endcase
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: Result=%h expected %h", tag, got, want);
        end
    endtask

    // Drive one pair, let it be captured, then check the pair captured three edges earlier.
    task automatic cycle(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input string tag);
        A1 = a;
        B1 = b;
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            hist[i] = hist[i-1];
            htag[i] = htag[i-1];
        end
        hist[0] = rst ? 32'h0 : want;
        htag[0] = tag;
        #1;
        check(htag[3], Result, hist[3]);
        @(negedge clk);
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 4; i++) begin
            hist[i] = 32'h0;
            htag[i] = "reset_flush";
        end
    endtask

    logic [31:0] dir_a [0:14];
    logic [31:0] dir_b [0:14];
    logic [31:0] dir_r [0:14];
    string       dir_t [0:14];

    initial begin
        logic [31:0] a, b;

        dir_a = '{32'h3FC00000, 32'h0FC00000, 32'hBFC00000, 32'h80000000, 32'h00000000,
                  32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h3F800000, 32'h3F800001,
                  32'hFF800000, 32'h40400000, 32'h80400000, 32'h00800000, 32'h3F800000};
        dir_b = '{32'h40200000, 32'h3FC00000, 32'h3FC00000, 32'h80000000, 32'h80000000,
                  32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h33800000, 32'h33800000,
                  32'h3F800000, 32'h00000000, 32'h80000000, 32'h80C00000, 32'hBF7FFFFF};
        dir_r = '{32'h40800000, 32'h3FC00000, 32'h00000000, 32'h80000000, 32'h00000000,
                  32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h3F800000, 32'h3F800002,
                  32'hFF800000, 32'h40400000, 32'h80000000, 32'h80000000, 32'h33800000};
        dir_t = '{"sum_1p5_2p5", "sticky_only", "exact_cancel", "neg_zero_sum", "mixed_zero_sum",
                  "overflow_inf", "inf_minus_inf", "nan_input", "tie_even_down", "tie_even_up",
                  "inf_plus_finite", "x_plus_zero", "subnormal_in_flush", "ftz_result",
                  "massive_cancel"};

        rst = 1'b1;
        A1  = 32'h0;
        B1  = 32'h0;
        clear_hist();
        #1;
        check("reset_async", Result, 32'h0);
        repeat (3) cycle(32'h3F800000, 32'h3F800000, 32'h0, "reset_hold");
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cycle(dir_a[i], dir_b[i], dir_r[i], dir_t[i]);
        end

        for (int i = 0; i < 200; i++) begin
            if (i == 80) begin
                #2 rst = 1'b1;
                #1;
                check("reset_midstream", Result, 32'h0);
                clear_hist();
                repeat (2) cycle($urandom, $urandom, 32'h0, "reset_midstream_hold");
                rst = 1'b0;
            end
            a = $urandom;
            b = rand_operand(a, int'($urandom_range(0, 3)));
            cycle(a, b, ref_add(a, b), $sformatf("rand%0d", i));
        end

        repeat (3) cycle(32'h0, 32'h0, 32'h0, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
